// File: rtl/pid_step.sv
//==============================================================================
// Module : pid_step
// Brief  : Multi-cycle PID control-effort stage with one shared multiplier.
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module pid_step #(
  parameter int DW = 8,
  parameter int KW = 8,
  parameter int IW = 16,
  parameter int OW = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        setpoint,
  input  logic [DW-1:0]        measured,
  input  logic [KW-1:0]        kp,
  input  logic [KW-1:0]        ki,
  input  logic [KW-1:0]        kd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] u,
  output logic                 sat
);

  localparam int MW = IW;            // multiplier operand B width (widest of e, integ, de)
  localparam int PW = KW + 1 + MW;
  localparam int TW = KW + IW + 3;

  localparam logic signed [IW:0]   c_imax = {2'b00, {(IW-1){1'b1}}};
  localparam logic signed [IW:0]   c_imin = {2'b11, {(IW-1){1'b0}}};
  localparam logic signed [TW-1:0] c_omax = {{(TW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [TW-1:0] c_omin = {{(TW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P    = 3'd1,
    S_I    = 3'd2,
    S_D    = 3'd3,
    S_SUM  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  state_t r_state, w_next;

  logic [KW-1:0]           r_kp, r_ki, r_kd;
  logic signed [DW:0]      r_e, r_e_prev;
  logic signed [IW-1:0]    r_integ, r_integ_next;
  logic signed [KW+DW+1:0] r_prod_p;
  logic signed [KW+IW:0]   r_prod_i;
  logic signed [KW+DW+2:0] r_prod_d;
  logic signed [OW-1:0]    r_u;
  logic                    r_sat, r_out_valid;

  logic                    w_accept;
  logic signed [DW:0]      w_e_in;
  logic signed [IW:0]      w_isum;
  logic signed [IW-1:0]    w_integ_next;
  logic signed [DW+1:0]    w_de;
  logic [KW-1:0]           w_gain;
  logic signed [MW-1:0]    w_opb;
  logic signed [PW-1:0]    w_mul;
  logic signed [TW-1:0]    w_total;
  logic                    w_clamp_hi, w_clamp_lo;
  logic signed [OW-1:0]    w_u;
  logic                    w_e_pos, w_e_neg;

  assign in_ready  = en && (r_state == S_IDLE);
  assign w_accept  = in_ready && in_valid && !clr;
  assign out_valid = r_out_valid;
  assign u         = r_u;
  assign sat       = r_sat;

  assign w_e_in = $signed({1'b0, setpoint}) - $signed({1'b0, measured});
  assign w_isum = {r_integ[IW-1], r_integ} + {{(IW-DW){r_e[DW]}}, r_e};
  assign w_integ_next = (w_isum > c_imax) ? c_imax[IW-1:0] :
                        (w_isum < c_imin) ? c_imin[IW-1:0] : w_isum[IW-1:0];
  assign w_de = {r_e[DW], r_e} - {r_e_prev[DW], r_e_prev};

  // Shared multiplier: gain and operand selected by the current phase
  always_comb begin
    w_gain = r_kp;
    w_opb  = {{(MW-DW-1){r_e[DW]}}, r_e};
    case (r_state)
      S_I: begin
        w_gain = r_ki;
        w_opb  = w_integ_next;
      end
      S_D: begin
        w_gain = r_kd;
        w_opb  = {{(MW-DW-2){w_de[DW+1]}}, w_de};
      end
      default: ;
    endcase
  end

  assign w_mul = $signed({1'b0, w_gain}) * w_opb;

  assign w_total = {{(IW-DW+1){r_prod_p[KW+DW+1]}}, r_prod_p}
                 + {{2{r_prod_i[KW+IW]}}, r_prod_i}
                 + {{(IW-DW){r_prod_d[KW+DW+2]}}, r_prod_d};
  assign w_clamp_hi = (w_total > c_omax);
  assign w_clamp_lo = (w_total < c_omin);
  assign w_u = w_clamp_hi ? c_omax[OW-1:0] :
               w_clamp_lo ? c_omin[OW-1:0] : w_total[OW-1:0];
  assign w_e_pos = !r_e[DW] && (r_e != '0);
  assign w_e_neg = r_e[DW];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_next = S_P;
        S_P:     w_next = S_I;
        S_I:     w_next = S_D;
        S_D:     w_next = S_SUM;
        S_SUM:   w_next = S_OUT;
        S_OUT:   if (r_out_valid && out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_kp         <= '0;
      r_ki         <= '0;
      r_kd         <= '0;
      r_e          <= '0;
      r_e_prev     <= '0;
      r_integ      <= '0;
      r_integ_next <= '0;
      r_prod_p     <= '0;
      r_prod_i     <= '0;
      r_prod_d     <= '0;
      r_u          <= '0;
      r_sat        <= 1'b0;
      r_out_valid  <= 1'b0;
    end else if (clr) begin
      r_integ     <= '0;
      r_e_prev    <= '0;
      r_u         <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_kp <= kp;
          r_ki <= ki;
          r_kd <= kd;
          r_e  <= w_e_in;
        end
        S_P: r_prod_p <= w_mul[KW+DW+1:0];
        S_I: begin
          r_integ_next <= w_integ_next;
          r_prod_i     <= w_mul;
        end
        S_D: r_prod_d <= w_mul[KW+DW+2:0];
        S_SUM: begin
          r_u      <= w_u;
          r_sat    <= w_clamp_hi || w_clamp_lo;
          r_e_prev <= r_e;
          // Anti-windup: freeze the integrator while pushing further into the clamp
          if (!((w_clamp_hi && w_e_pos) || (w_clamp_lo && w_e_neg)))
            r_integ <= r_integ_next;
        end
        S_OUT: begin
          if (!r_out_valid)    r_out_valid <= 1'b1;
          else if (out_ready)  r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
